// File: rtl/core_pkg.sv
// Shared definitions for the riscv32 core front end.
//   XLEN          : architectural register / address width
//   NOP_INST      : canonical NOP (addi x0, x0, 0)
//   fetch_entry_t : {pc, inst} pair handed from fetch to decode
//   word_align    : clears the two low address bits
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO used for the outstanding-request PC tags and
// for the fetch queue.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (storage cleared)
//   flush      : empties the FIFO (takes priority over push/pop)
//   push       : write push_data at the tail
//   push_data  : WIDTH-bit entry
//   pop        : remove the head (ignored when empty)
//   head       : current head entry
//   count      : number of valid entries, 0..DEPTH
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Callers size their traffic by credits, so a push into a full FIFO
  // without a simultaneous pop is a design error.
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && !do_pop && (count == FULL)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues in-order imem requests,
// buffers responses and hands {pc, inst} to decode.
// Optional build macro: MISALIGN_TRAP_EN (adds if_misalign and the
// misaligned-target trap entry; otherwise target low bits are ignored).
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   redirect_valid, redirect_pc    : taken branch/jump from execute
//   imem_req_valid/ready/addr      : fetch request channel
//   imem_rsp_valid, imem_rsp_data  : in-order responses, no back-pressure
//   if_valid, if_ready, if_pc, if_inst : decode handshake
//   if_misalign (MISALIGN_TRAP_EN) : head is a misaligned-target trap entry
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            if_misalign
`endif
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   q_cnt;
  logic [CW-1:0]   drop_cnt;
  logic [XLEN-1:0] tag_pc;
  fetch_entry_t    q_head;
  fetch_entry_t    q_in;
  logic            credit_ok;
  logic            fetch_stop;
  logic            head_valid;
  logic            req_fire;
  logic            q_push;
  logic            q_pop;

  // Outstanding requests plus queued entries never exceed DEPTH, so every
  // response has a queue slot waiting for it.
  assign credit_ok      = ({1'b0, out_cnt} + {1'b0, q_cnt}) < CREDITS;
  assign imem_req_valid = rst_n && !redirect_valid && credit_ok && !fetch_stop;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign q_push = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign q_in   = '{pc: tag_pc, inst: imem_rsp_data};

  assign if_valid = head_valid && !redirect_valid;
  assign q_pop    = if_valid && if_ready;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc),
    .pop       (imem_rsp_valid),
    .head      (tag_pc),
    .count     (out_cnt)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fetch_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_cnt)
  );

  // out_cnt already includes responses marked for dropping, so after a
  // redirect every request still in flight beyond this cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc       <= word_align(redirect_pc);
      drop_cnt <= out_cnt - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc <= pc + 32'd4;
      end
      if (imem_rsp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic            mis_flag;
  logic            mis_done;
  logic [XLEN-1:0] mis_pc;
  logic            trap_valid;

  // Trap entry appears once the queue is empty and is presented only once.
  assign fetch_stop  = mis_flag;
  assign trap_valid  = mis_flag && !mis_done && (q_cnt == '0);
  assign head_valid  = (q_cnt != '0) || trap_valid;
  assign if_pc       = trap_valid ? mis_pc : q_head.pc;
  assign if_inst     = trap_valid ? NOP_INST : q_head.inst;
  assign if_misalign = trap_valid && if_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mis_flag <= 1'b0;
      mis_done <= 1'b0;
      mis_pc   <= '0;
    end else if (redirect_valid) begin
      mis_flag <= |redirect_pc[1:0];
      mis_done <= 1'b0;
      mis_pc   <= redirect_pc;
    end else if (trap_valid && q_pop) begin
      mis_done <= 1'b1;
    end
  end
`else
  logic unused_target_low_bits;

  // Target low bits are architecturally ignored in this build.
  assign unused_target_low_bits = ^redirect_pc[1:0];
  assign fetch_stop = 1'b0;
  assign head_valid = (q_cnt != '0);
  assign if_pc      = q_head.pc;
  assign if_inst    = q_head.inst;
`endif

endmodule
